// File: rtl/key_filter.sv
// key_filter: push-button debouncer for the bulk-erase trigger.
// Synchronises the active-low button, filters contact bounce with a
// four-state one-hot FSM, and emits one key_flag pulse per press plus a
// debounced key_state level.
// Optional feature: define KEY_LONG_PRESS_EN to add LONG_MAX and the
// key_long_flag output (one pulse per press held for LONG_MAX cycles).
module key_filter #(
  parameter int CNT_MAX = 999_999
`ifdef KEY_LONG_PRESS_EN
  ,
  parameter int LONG_MAX = 49_999_999
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state
`ifdef KEY_LONG_PRESS_EN
  ,
  output logic key_long_flag
`endif
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    FILT_DN = 4'b0010,
    DOWN    = 4'b0100,
    FILT_UP = 4'b1000
  } state_t;

  logic          sync1_q, sync2_q;
  logic          key_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_flag_q, key_flag_d;
  logic          key_state_q, key_state_d;

  // Two-flop synchroniser; resets to the idle (released) level so reset
  // release can never look like a press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign key_s = sync2_q;

  // Next-state and counter logic; a bounce wins over a same-cycle match.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (!key_s) state_d = FILT_DN;
      end
      FILT_DN: begin
        if (key_s)                  state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = DOWN;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      DOWN: begin
        if (key_s) state_d = FILT_UP;
      end
      FILT_UP: begin
        if (!key_s)                 state_d = DOWN;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    key_flag_d  = (state_q == FILT_DN) && (state_d == DOWN);
    key_state_d = (state_d == DOWN) || (state_d == FILT_UP);
  end

  // FSM, counter and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_flag_q  <= 1'b0;
      key_state_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_flag_q  <= key_flag_d;
      key_state_q <= key_state_d;
    end
  end

  assign key_flag  = key_flag_q;
  assign key_state = key_state_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_MAX);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);

  logic [LW-1:0] long_cnt_q, long_cnt_d;
  logic          long_flag_q, long_flag_d;
  logic          long_active;

  // Long-hold counter: runs while pressed, saturates so it pulses only once.
  always_comb begin
    long_active = (state_q == DOWN) || (state_q == FILT_UP);
    long_cnt_d  = '0;
    long_flag_d = 1'b0;
    if (long_active) begin
      if (long_cnt_q != LONG_LAST) begin
        long_cnt_d  = long_cnt_q + 1'b1;
        long_flag_d = (long_cnt_q == (LONG_LAST - 1'b1));
      end else begin
        long_cnt_d  = long_cnt_q;
      end
    end
  end

  // Long-hold counter and pulse registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt_q  <= '0;
      long_flag_q <= 1'b0;
    end else begin
      long_cnt_q  <= long_cnt_d;
      long_flag_q <= long_flag_d;
    end
  end

  assign key_long_flag = long_flag_q;
`endif

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Debounces the active-low board push button and produces the single-cycle `key` trigger consumed by the flash bulk-erase controller.
- Sits directly upstream of that controller on the same 50 MHz `sys_clk` domain.
- Removes the need for that controller to tolerate contact bounce or long holds.
- Guarantees exactly one trigger pulse per physical press.

Parameters:
- CNT_MAX, 999_999, debounce window in sys_clk cycles (20 ms at 50 MHz). Legal values ≥ 2. Simulation override is 20.

Ports:
- sys_clk  input  1  system clock, 50 MHz
- sys_rst_n  input  1  asynchronous active-low reset
- key_in  input  1  raw button pin; active-low, idles high, asynchronous to sys_clk
- key_flag  output  1  one-cycle high pulse per debounced press; drives the erase controller `key` input
- key_state  output  1  debounced level: 1 = pressed, 0 = released

Behaviour:
- Clock and reset: one clock, `sys_clk`. Reset `sys_rst_n` is asynchronous and active-low. All flops reset asynchronously.
- Reset values:
  - key_flag = 0, key_state = 0.
  - state = IDLE, debounce counter = 0.
  - Both synchroniser flops = 1 (idle level), so reset release never looks like a press.
- Synchroniser: key_in passes through a 2-flop synchroniser; the output is key_s. The FSM uses only key_s.
- Counter:
  - Width is $clog2(CNT_MAX).
  - Cleared on every state change.
  - Increments only in FILT_DN and FILT_UP.
  - Never wraps; it is cleared at the CNT_MAX-1 match.
- FSM, one-hot, 4 states:
  - IDLE: key_s = 0 -> FILT_DN; otherwise stay.
  - FILT_DN:
    - key_s = 1 -> IDLE (bounce rejected, counter cleared).
    - key_s = 0 and counter = CNT_MAX-1 -> DOWN.
    - Otherwise counter +1.
  - DOWN: key_s = 1 -> FILT_UP; otherwise stay.
  - FILT_UP:
    - key_s = 0 -> DOWN (release bounce rejected).
    - key_s = 1 and counter = CNT_MAX-1 -> IDLE.
    - Otherwise counter +1.
  - Unreachable encodings -> IDLE.
- key_flag:
  - Registered. Set for exactly one cycle on the FILT_DN -> DOWN transition, i.e. high in the first cycle state = DOWN.
  - Never asserted on release or in any other state.
  - Never re-asserts while held.
- key_state: registered, 1 while state is DOWN or FILT_UP, 0 in IDLE or FILT_DN.
- Latency:
  - Edge 0 is the first sys_clk edge that samples key_in = 0, with key_in held stable after it.
  - key_flag and key_state rise after edge CNT_MAX+2.
  - key_state falls CNT_MAX+2 edges after key_in returns high and stays high.
- Simultaneous events: a bounce that occurs in the same cycle as the CNT_MAX-1 match takes priority. The state returns to IDLE (from FILT_DN) or DOWN (from FILT_UP), and no flag is generated.
- Glitch tolerance: a key_in low pulse shorter than CNT_MAX cycles never produces key_flag.
- Reset mid-operation: outputs drop to 0 immediately, asynchronously. The FSM restarts in IDLE. A button still held at reset release is treated as a new press: after CNT_MAX+2 edges it yields one key_flag.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- With the macro defined, the block adds:
  - Parameter LONG_MAX, default 49_999_999 (1 s).
  - Output port key_long_flag, 1 bit, reset 0.
  - A long counter of width $clog2(LONG_MAX), cleared in IDLE and FILT_DN, counting while in DOWN or FILT_UP.
- key_long_flag pulses high for one cycle when the long counter reaches LONG_MAX-1. The counter then saturates, so there is at most one long pulse per press.
- key_flag behaviour is unchanged.
- Without the macro: no port, no parameter, no long counter.

Test Plan:
- CNT_MAX=20. Reset, then drive key_in low at a clean edge and hold it -> key_flag high for exactly 1 cycle after edge 22; key_state = 1 from the same cycle.
- CNT_MAX=20. Key_in low 10 cycles, high 3, low 10, high 3, then low steady -> no key_flag during the bounces; one key_flag 22 edges after the final falling sample.
- CNT_MAX=20. Hold pressed 500 cycles, then release with 2 bounces of 5 cycles each -> key_state stays 1 through the bounces; falls 22 edges after the last rising sample; no second key_flag.
- CNT_MAX=20. Assert sys_rst_n = 0 at counter = 10 in FILT_DN while key_in is held low; release reset -> outputs 0 during reset; one key_flag 22 edges after reset release.
- CNT_MAX=20. key_in low for 19 cycles only, then high -> key_flag and key_state never assert; state returns to IDLE.
- KEY_LONG_PRESS_EN, LONG_MAX=100, CNT_MAX=20. Hold the button 300 cycles -> key_flag once after edge 22; key_long_flag once, 100 cycles after entering DOWN; no further pulses.
